// File: rtl/hamming_burst_decoder.sv
// Collects a burst of eight 12-bit Hamming codewords, corrects single-bit errors and replays the bytes with per-word flags.
// Optional HBD_ERR_COUNT_EN builds the corrected-word counter and sticky overrun flag; otherwise both read as 0.
module hamming_burst_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        err_corr,
    output logic        err_uncorr,
    output logic [3:0]  err_count,
    output logic        overrun,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECODE  = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t      cur_st;
    state_t      nxt_st;
    logic [2:0]  idx;
    logic [11:0] rbuf  [8];
    logic [7:0]  dbuf  [8];
    logic [1:0]  flags [8];

    logic [11:0] cw;
    logic [11:0] cw_fix;
    logic [3:0]  syn;
    logic        syn_corr;
    logic        syn_uncorr;
    logic [7:0]  dec_byte;

    assign state = cur_st;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_st <= IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            IDLE:    if (in_valid) nxt_st = COLLECT;
            COLLECT: if (in_valid && idx == 3'd7) nxt_st = DECODE;
            DECODE:  if (idx == 3'd7) nxt_st = OUTPUT;
            OUTPUT:  if (idx == 3'd7) nxt_st = IDLE;
            default: nxt_st = IDLE;
        endcase
    end

    // Bit i-1 of the codeword is Hamming position i.
    always_comb begin
        cw         = rbuf[idx];
        syn[0]     = cw[0] ^ cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10];
        syn[1]     = cw[1] ^ cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10];
        syn[2]     = cw[3] ^ cw[4] ^ cw[5] ^ cw[6] ^ cw[11];
        syn[3]     = cw[7] ^ cw[8] ^ cw[9] ^ cw[10] ^ cw[11];
        syn_corr   = (syn != 4'd0) && (syn <= 4'd12);
        syn_uncorr = (syn >= 4'd13);
        cw_fix     = cw ^ (syn_corr ? (12'd1 << (syn - 4'd1)) : 12'd0);
        dec_byte   = {cw_fix[11], cw_fix[10], cw_fix[9], cw_fix[8],
                      cw_fix[6],  cw_fix[5],  cw_fix[4], cw_fix[2]};
    end

    // Buffers are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (in_valid && (cur_st == IDLE || cur_st == COLLECT)) begin
            rbuf[(cur_st == IDLE) ? 3'd0 : idx] <= in_data;
        end
        if (cur_st == DECODE) begin
            dbuf[idx]  <= dec_byte;
            flags[idx] <= {syn_uncorr, syn_corr};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= 3'd0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
        end else begin
            case (cur_st)
                IDLE: begin
                    out_valid  <= 1'b0;
                    out_data   <= 8'h00;
                    err_corr   <= 1'b0;
                    err_uncorr <= 1'b0;
                    if (in_valid) idx <= 3'd1;
                end
                COLLECT: begin
                    if (in_valid) idx <= idx + 3'd1;
                end
                DECODE: begin
                    idx <= idx + 3'd1;
                end
                OUTPUT: begin
                    out_valid  <= 1'b1;
                    out_data   <= dbuf[idx];
                    err_corr   <= flags[idx][0];
                    err_uncorr <= flags[idx][1];
                    idx        <= idx + 3'd1;
                end
                default: idx <= 3'd0;
            endcase
        end
    end

`ifdef HBD_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= 4'd0;
            overrun   <= 1'b0;
        end else if (cur_st == IDLE && in_valid) begin
            err_count <= 4'd0;
            overrun   <= 1'b0;
        end else begin
            if (cur_st == DECODE && syn_corr && err_count != 4'd8) begin
                err_count <= err_count + 4'd1;
            end
            if (in_valid && (cur_st == DECODE || cur_st == OUTPUT)) begin
                overrun <= 1'b1;
            end
        end
    end
`else
    assign err_count = 4'd0;
    assign overrun   = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_burst_decoder.sv
// Directed table-driven bench for hamming_burst_decoder: clean, corrected, uncorrectable, gapped, overrun/back-to-back and reset bursts.
module tb_hamming_burst_decoder;

`ifdef HBD_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        err_corr;
    logic        err_uncorr;
    logic [3:0]  err_count;
    logic        overrun;
    logic [1:0]  state;

    hamming_burst_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .err_corr  (err_corr),
        .err_uncorr(err_uncorr),
        .err_count (err_count),
        .overrun   (overrun),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] cw;
        logic [7:0]  exp_data;
        logic        exp_corr;
        logic        exp_uncorr;
    } vec_t;

    vec_t tbl [24];
    int   exp_cnt [3];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] enc(input logic [7:0] d);
        logic [12:1] p;
        p     = '0;
        p[3]  = d[0];
        p[5]  = d[1];
        p[6]  = d[2];
        p[7]  = d[3];
        p[9]  = d[4];
        p[10] = d[5];
        p[11] = d[6];
        p[12] = d[7];
        p[1]  = p[3] ^ p[5] ^ p[7] ^ p[9] ^ p[11];
        p[2]  = p[3] ^ p[6] ^ p[7] ^ p[10] ^ p[11];
        p[4]  = p[5] ^ p[6] ^ p[7] ^ p[12];
        p[8]  = p[9] ^ p[10] ^ p[11] ^ p[12];
        return p;
    endfunction

    function automatic logic [11:0] pos(input int p);
        logic [11:0] m;
        m = 12'd1 << (p - 1);
        return m;
    endfunction

    task automatic set_vec(input int i, input logic [7:0] d, input logic [11:0] flip,
                           input logic [7:0] ed, input logic c, input logic u);
        tbl[i].cw         = enc(d) ^ flip;
        tbl[i].exp_data   = ed;
        tbl[i].exp_corr   = c;
        tbl[i].exp_uncorr = u;
    endtask

    // Entered and left at a falling edge. With chain set, returns right after edge E+16
    // so the caller's next word is sampled at E+17.
    task automatic run_burst(input int b, input bit gap, input bit pulse, input bit chain);
        int base;
        int first_k;
        int last_k;
        base    = b * 8;
        first_k = -1;
        last_k  = chain ? 16 : 17;
        for (int w = 0; w < 8; w++) begin
            if (gap && w == 4) begin
                in_valid = 1'b0;
                repeat (3) @(negedge clk);
                chk("gap_hold_state", state, 2'd1);
            end
            if (w == 1) begin
                chk("start_state", state, 2'd1);
                chk("start_out_valid", out_valid, 1'b0);
                chk("start_overrun", overrun, 1'b0);
                chk("start_err_count", err_count, 4'd0);
            end
            in_valid = 1'b1;
            in_data  = tbl[base + w].cw;
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            if (out_valid && first_k < 0) first_k = k;
            if (k >= 9 && k <= 16) begin
                chk($sformatf("b%0d_w%0d_valid", b, k - 9), out_valid, 1'b1);
                chk($sformatf("b%0d_w%0d_data", b, k - 9), out_data, tbl[base + k - 9].exp_data);
                chk($sformatf("b%0d_w%0d_corr", b, k - 9), err_corr, tbl[base + k - 9].exp_corr);
                chk($sformatf("b%0d_w%0d_uncorr", b, k - 9), err_uncorr, tbl[base + k - 9].exp_uncorr);
            end
            if (pulse && (k == 12 || k == 16)) chk("overrun_in_output", overrun, CNT_EN);
            if (k == 16) begin
                chk("end_state_idle", state, 2'd0);
                chk("end_err_count", err_count, CNT_EN ? exp_cnt[b] : 0);
            end
            if (k == 17) chk("valid_drop", out_valid, 1'b0);
            in_valid = pulse && (k == 3);
            in_data  = 12'h5A5;
        end
        chk("latency", first_k, 9);
    endtask

    initial begin
        int vcnt;
        set_vec(0,  8'h00, 12'h0, 8'h00, 1'b0, 1'b0);
        set_vec(1,  8'h01, 12'h0, 8'h01, 1'b0, 1'b0);
        set_vec(2,  8'h7F, 12'h0, 8'h7F, 1'b0, 1'b0);
        set_vec(3,  8'h80, 12'h0, 8'h80, 1'b0, 1'b0);
        set_vec(4,  8'hA5, 12'h0, 8'hA5, 1'b0, 1'b0);
        set_vec(5,  8'h5A, 12'h0, 8'h5A, 1'b0, 1'b0);
        set_vec(6,  8'hFE, 12'h0, 8'hFE, 1'b0, 1'b0);
        set_vec(7,  8'hFF, 12'h0, 8'hFF, 1'b0, 1'b0);
        set_vec(8,  8'h12, 12'h0, 8'h12, 1'b0, 1'b0);
        set_vec(9,  8'h34, 12'h0, 8'h34, 1'b0, 1'b0);
        set_vec(10, 8'hA5, pos(6), 8'hA5, 1'b1, 1'b0);
        set_vec(11, 8'h56, 12'h0, 8'h56, 1'b0, 1'b0);
        set_vec(12, 8'h78, 12'h0, 8'h78, 1'b0, 1'b0);
        set_vec(13, 8'h9A, 12'h0, 8'h9A, 1'b0, 1'b0);
        set_vec(14, 8'hBC, 12'h0, 8'hBC, 1'b0, 1'b0);
        set_vec(15, 8'hDE, 12'h0, 8'hDE, 1'b0, 1'b0);
        set_vec(16, 8'h3C, pos(8), 8'h3C, 1'b1, 1'b0);
        set_vec(17, 8'h01, 12'h0, 8'h01, 1'b0, 1'b0);
        // Positions 7 and 8 flipped: syndrome 15, d3 left inverted (0xC3 ^ 0x08).
        set_vec(18, 8'hC3, pos(7) | pos(8), 8'hCB, 1'b0, 1'b1);
        set_vec(19, 8'h02, 12'h0, 8'h02, 1'b0, 1'b0);
        set_vec(20, 8'h40, 12'h0, 8'h40, 1'b0, 1'b0);
        set_vec(21, 8'h81, 12'h0, 8'h81, 1'b0, 1'b0);
        set_vec(22, 8'h99, 12'h0, 8'h99, 1'b0, 1'b0);
        set_vec(23, 8'h66, 12'h0, 8'h66, 1'b0, 1'b0);
        exp_cnt[0] = 0;
        exp_cnt[1] = 1;
        exp_cnt[2] = 1;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 12'h000;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 2'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_err_corr", err_corr, 1'b0);
        chk("rst_err_uncorr", err_uncorr, 1'b0);
        chk("rst_err_count", err_count, 4'd0);
        chk("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        run_burst(0, 1'b0, 1'b0, 1'b0);
        run_burst(1, 1'b0, 1'b0, 1'b0);
        run_burst(2, 1'b0, 1'b0, 1'b0);
        run_burst(0, 1'b1, 1'b0, 1'b0);
        run_burst(1, 1'b0, 1'b1, 1'b1);
        run_burst(2, 1'b0, 1'b0, 1'b0);

        for (int w = 0; w < 5; w++) begin
            in_valid = 1'b1;
            in_data  = tbl[8 + w].cw;
            @(negedge clk);
        end
        chk("pre_reset_state", state, 2'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_state", state, 2'd0);
        chk("midrst_err_count", err_count, 4'd0);
        vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("midrst_no_output", vcnt, 0);
        chk("midrst_idle", state, 2'd0);
        run_burst(1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
